// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite memory slave.
// Contents: response codes, the write/read path state types, and the
// byte-address to word-index helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Word index = addr[lsb+idx_w-1 : lsb]; the byte offset below lsb is dropped.
    function automatic logic [31:0] word_index(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage

// File: rtl/axi_lite_bytemem.sv
// Byte-lane RAM: one strobed write port and one registered read port.
// Ports:
//   clk, rst      clock and synchronous active-high reset (read register only)
//   wen/widx      write enable and word index
//   wdata/wstrb   write data and per-byte enables
//   ren/ridx      read enable and word index
//   rdata         registered read data (read-first against a same-edge write)
module axi_lite_bytemem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 4096
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               wen,
    input  logic [$clog2(MEM_BYTES/(DATA_WIDTH/8))-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]                              wdata,
    input  logic [DATA_WIDTH/8-1:0]                            wstrb,
    input  logic                                               ren,
    input  logic [$clog2(MEM_BYTES/(DATA_WIDTH/8))-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]                              rdata
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned WORDS  = MEM_BYTES / STRB_W;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is never reset; only strobed lanes are updated.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb[i]) begin
                    mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register samples the pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (ren) begin
            rdata_q <= mem_q[ridx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave with a local byte-addressed RAM.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   AW*/W*/B*             write address, data and response channels
//   AR*/R*                read address and data channels
// Writes capture AW and W independently, commit for one cycle, then respond.
// Reads are single beat with one cycle latency. Out-of-range -> SLVERR, no access.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 4096
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_BYTES / STRB_W);

    // Write path state
    wr_state_t             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      awidx_q, awidx_d;
    logic                  aw_ok_q, aw_ok_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // Read path state
    rd_state_t             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_err_q, rd_err_d;

    logic                  aw_in_range_c, ar_in_range_c;
    logic                  mem_wen_c, mem_ren_c;
    logic [IDX_W-1:0]      mem_ridx_c;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign aw_in_range_c = AWADDR < ADDR_WIDTH'(MEM_BYTES);
    assign ar_in_range_c = ARADDR < ADDR_WIDTH'(MEM_BYTES);

    // Write path: independent AW/W capture, one commit cycle, then hold B.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        aw_ok_d    = aw_ok_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mem_wen_c  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    awready_d = 1'b0;
                    awidx_d   = IDX_W'(word_index(64'(AWADDR), LSB, IDX_W));
                    aw_ok_d   = aw_in_range_c;
                end
                if (WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wready_d = 1'b0;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (aw_held_q && w_held_q) begin
                    wr_state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                // A reset at this edge must not let the write land.
                mem_wen_c  = aw_ok_q && !ARESET;
                bvalid_d   = 1'b1;
                bresp_d    = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
                wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (BREADY) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read path: accept AR, present registered data until R handshake.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rd_err_d   = rd_err_q;
        mem_ren_c  = 1'b0;
        mem_ridx_c = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (ARVALID && arready_q) begin
                    mem_ren_c  = ar_in_range_c && !ARESET;
                    mem_ridx_c = IDX_W'(word_index(64'(ARADDR), LSB, IDX_W));
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rresp_d    = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    rd_err_d   = !ar_in_range_c;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            aw_ok_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            aw_ok_q    <= aw_ok_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rd_err_q   <= rd_err_d;
        end
    end

    axi_lite_bytemem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_BYTES  (MEM_BYTES)
    ) u_mem (
        .clk   (ACLK),
        .rst   (ARESET),
        .wen   (mem_wen_c),
        .widx  (awidx_q),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .ren   (mem_ren_c),
        .ridx  (mem_ridx_c),
        .rdata (mem_rdata)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    // Out-of-range reads return zero regardless of the last RAM read.
    assign RDATA   = rd_err_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed plus randomized checks of axi_lite_slave_mem against a word-array model.
module tb_axi_lite_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [1024];
    bit          known   [1024];

    always #5 ACLK = ~ACLK;

    axi_lite_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_BYTES  (4096)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: byte merge into a word array; a word is known once fully written.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        if (addr >= 32'd4096) return;
        idx = int'(addr[11:2]);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) ref_mem[idx][8*i +: 8] = data[8*i +: 8];
        end
        if (strb == 4'hf) known[idx] = 1'b1;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_hold);
        bit         aw_done = 1'b0;
        bit         w_done  = 1'b0;
        bit         hs_aw, hs_w;
        int         cyc = 0;
        int         lat = 0;
        logic [1:0] exp_resp;
        exp_resp = (addr < 32'd4096) ? 2'b00 : 2'b10;
        AWADDR = addr;
        WDATA  = data;
        WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 64) begin
            AWVALID = (cyc >= aw_dly) && !aw_done;
            WVALID  = (cyc >= w_dly) && !w_done;
            hs_aw   = AWVALID && AWREADY;
            hs_w    = WVALID && WREADY;
            tick();
            cyc++;
            if (hs_aw) aw_done = 1'b1;
            if (hs_w)  w_done  = 1'b1;
            if (!(aw_done && w_done)) begin
                if (aw_done) chk("awready_while_held", 64'(AWREADY), 64'(0));
                if (w_done)  chk("wready_while_held", 64'(WREADY), 64'(0));
            end
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("wr_handshake_timeout", 64'(aw_done && w_done), 64'(1));
        while (!BVALID && lat < 16) begin
            tick();
            lat++;
        end
        chk("b_latency", 64'(lat), 64'(2));
        chk("bresp", 64'(BRESP), 64'(exp_resp));
        for (int k = 0; k < b_hold; k++) begin
            AWVALID = 1'b1;
            tick();
            chk("b_hold_bvalid", 64'(BVALID), 64'(1));
            chk("b_hold_bresp", 64'(BRESP), 64'(exp_resp));
            chk("b_hold_rdy", 64'({AWREADY, WREADY}), 64'(0));
        end
        AWVALID = 1'b0;
        BREADY  = 1'b1;
        tick();
        BREADY  = 1'b0;
        chk("b_done", 64'({BVALID, AWREADY, WREADY}), 64'(3'b011));
        if (exp_resp == 2'b00) model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_hold, output logic [31:0] data);
        bit hs;
        bit done = 1'b0;
        int cyc  = 0;
        int idx;
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (!done && cyc < 64) begin
            hs = ARREADY;
            tick();
            cyc++;
            if (hs) done = 1'b1;
        end
        ARVALID = 1'b0;
        chk("rd_handshake_timeout", 64'(done), 64'(1));
        chk("rvalid_next_cycle", 64'(RVALID), 64'(1));
        chk("arready_low", 64'(ARREADY), 64'(0));
        if (addr >= 32'd4096) begin
            chk("rresp_slverr", 64'(RRESP), 64'(2'b10));
            chk("rdata_oor_zero", 64'(RDATA), 64'(0));
        end else begin
            idx = int'(addr[11:2]);
            chk("rresp_okay", 64'(RRESP), 64'(2'b00));
            if (known[idx]) chk("rdata_model", 64'(RDATA), 64'(ref_mem[idx]));
        end
        data = RDATA;
        for (int k = 0; k < r_hold; k++) begin
            tick();
            chk("r_hold_rvalid", 64'(RVALID), 64'(1));
            chk("r_hold_rdata", 64'(RDATA), 64'(data));
            chk("r_hold_arready", 64'(ARREADY), 64'(0));
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("r_done", 64'({RVALID, ARREADY}), 64'(2'b01));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a, d;
        logic [3:0]  s;

        for (int i = 0; i < 1024; i++) known[i] = 1'b0;
        ARESET  = 1'b1;
        AWVALID = 1'b0; AWADDR = '0;
        WVALID  = 1'b0; WDATA  = '0; WSTRB = '0;
        BREADY  = 1'b0;
        ARVALID = 1'b0; ARADDR = '0;
        RREADY  = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;

        // Reset state
        chk("rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
        chk("rst_valids", 64'({BVALID, RVALID}), 64'(0));
        chk("rst_resps", 64'({BRESP, RRESP}), 64'(0));
        chk("rst_rdata", 64'(RDATA), 64'(0));

        // AW and W together, then readback
        axi_write(32'h10, 32'hDEADBEEF, 4'hf, 0, 0, 0);
        axi_read(32'h10, 0, rd);
        chk("tp1_readback", 64'(rd), 64'(32'hDEADBEEF));

        // W three cycles ahead of AW, partial strobes
        axi_write(32'h20, 32'hAAAAAAAA, 4'hf, 0, 0, 0);
        axi_write(32'h20, 32'h11223344, 4'b0101, 3, 0, 0);
        axi_read(32'h20, 0, rd);
        chk("tp2_merge", 64'(rd), 64'(32'hAA22AA44));

        // AW ahead of W, zero strobe writes nothing
        axi_write(32'h24, 32'h0BADF00D, 4'hf, 0, 2, 0);
        axi_write(32'h24, 32'hFFFFFFFF, 4'h0, 0, 1, 0);
        axi_read(32'h24, 0, rd);
        chk("wstrb_zero", 64'(rd), 64'(32'h0BADF00D));

        // Out of range write and read
        axi_write(32'h0, 32'h12345678, 4'hf, 0, 0, 0);
        axi_write(32'h1000, 32'hFFFFFFFF, 4'hf, 0, 0, 0);
        axi_read(32'h0, 0, rd);
        chk("oor_no_alias", 64'(rd), 64'(32'h12345678));
        axi_read(32'h2000, 0, rd);
        chk("oor_rdata", 64'(rd), 64'(0));

        // Backpressure on B and R
        axi_write(32'h28, 32'hCAFEF00D, 4'hf, 0, 0, 5);
        axi_read(32'h28, 4, rd);

        // Same-edge collision: read samples the commit edge and sees old data
        axi_write(32'h30, 32'h1, 4'hf, 0, 0, 0);
        AWADDR = 32'h30; WDATA = 32'h2; WSTRB = 4'hf;
        AWVALID = 1'b1; WVALID = 1'b1;
        chk("col_ready", 64'({AWREADY, WREADY}), 64'(2'b11));
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        ARADDR = 32'h30; ARVALID = 1'b1;
        chk("col_arready", 64'(ARREADY), 64'(1));
        tick();
        ARVALID = 1'b0;
        chk("col_bvalid", 64'(BVALID), 64'(1));
        chk("col_rvalid", 64'(RVALID), 64'(1));
        chk("col_old_data", 64'(RDATA), 64'(32'h1));
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        model_write(32'h30, 32'h2, 4'hf);
        axi_read(32'h30, 0, rd);
        chk("col_new_data", 64'(rd), 64'(32'h2));

        // Reset while W is held and AW not yet seen
        axi_write(32'h40, 32'h55, 4'hf, 0, 0, 0);
        WDATA = 32'h99; WSTRB = 4'hf; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("mid_w_held", 64'(WREADY), 64'(0));
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("mid_rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
        chk("mid_rst_valids", 64'({BVALID, RVALID}), 64'(0));
        axi_read(32'h40, 0, rd);
        chk("mid_rst_unchanged", 64'(rd), 64'(32'h55));
        // Lone AW after reset must wait for a fresh W
        AWADDR = 32'h40; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        tick(); tick(); tick();
        chk("mid_no_stale_commit", 64'(BVALID), 64'(0));
        WDATA = 32'h77; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        tick(); tick();
        chk("mid_late_w_bvalid", 64'(BVALID), 64'(1));
        chk("mid_late_w_bresp", 64'(BRESP), 64'(0));
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        model_write(32'h40, 32'h77, 4'hf);
        axi_read(32'h40, 0, rd);
        chk("mid_late_w_data", 64'(rd), 64'(32'h77));

        // Randomized traffic over a small window of words
        for (int i = 0; i < 16; i++) axi_write(32'(i) << 2, $urandom, 4'hf, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            else
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)));
            else
                axi_read(a, int'($urandom_range(0, 2)), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
AXI4-Lite slave endpoint with a local byte-addressed RAM. It sits directly downstream of the AXI master and consumes its AW/W/B/AR/R channel traffic. Writes use independent address/data capture with WSTRB byte-lane merge. Reads are single-beat and registered. Out-of-range accesses return SLVERR without touching memory.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR
DATA_WIDTH, 32, width of WDATA/RDATA; WSTRB is DATA_WIDTH/8
MEM_BYTES, 4096, RAM size in bytes; power of 2, multiple of DATA_WIDTH/8

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  reset, synchronous, active-high
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  ADDR_WIDTH  write byte address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables; bit i gates WDATA[8i+7:8i]
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  00 OKAY, 10 SLVERR
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  ADDR_WIDTH  read byte address
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset (ARESET=1 at an edge): AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0; all held flags cleared. RAM contents are not reset.
- Reset mid-transaction aborts it: a held AW or W is discarded, a pending B or R is dropped, and no RAM write occurs.
- Handshake = VALID && READY at a rising edge.
- Outputs never depend combinationally on inputs. All READY/VALID signals are registered.
- Word index = addr[log2(MEM_BYTES)-1 : log2(DATA_WIDTH/8)]. Low offset bits are ignored (access is word-aligned).
- Range check: in_range = (addr < MEM_BYTES), computed on the full ADDR_WIDTH.

Write path, states WR_IDLE, WR_COMMIT, WR_RESP:
- WR_IDLE: AW and W are captured independently into aw_held/w_held registers.
  - AWREADY deasserts the cycle after an AW capture.
  - WREADY deasserts the cycle after a W capture.
  - AW and W may arrive in the same cycle or in either order, any number of cycles apart.
- When both are held -> WR_COMMIT (1 cycle).
  - If in_range: each byte with WSTRB[i]=1 is written; bytes with WSTRB[i]=0 keep their value. WSTRB=0 writes nothing but still returns OKAY.
  - If out of range: no write; BRESP=10.
- Next edge -> WR_RESP with BVALID=1. BVALID and BRESP stay stable until BREADY.
- On the B handshake -> WR_IDLE: BVALID=0, AWREADY=1, WREADY=1, flags cleared.
- Latency with both handshakes at edge N and BREADY=1: BVALID high after edge N+2.

Read path, states RD_IDLE, RD_RESP:
- RD_IDLE: ARREADY=1. On the AR handshake -> RD_RESP at the next edge, with:
  - ARREADY=0, RVALID=1
  - RDATA = RAM word (in range) or 0 with RRESP=10 (out of range)
- Read latency: RVALID high in the cycle after the AR handshake.
- RDATA and RRESP stay stable while RVALID=1 && !RREADY.
- On the R handshake -> RD_IDLE, ARREADY=1. Back-to-back reads run at one every 2 cycles.

Concurrency:
- Read and write paths are fully independent.
- Same-word collision: if a read samples at the same edge as a WR_COMMIT to that word, RDATA returns the pre-write data. A read sampled at any later edge sees the new data.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - typedefs wr_state_t {WR_IDLE, WR_COMMIT, WR_RESP} and rd_state_t {RD_IDLE, RD_RESP}
  - function word_index(addr)
- One sub-module, axi_lite_bytemem: the byte-lane RAM, with one write port (wen, widx, wdata, wstrb) and one synchronous read port (ren, ridx -> rdata, registered). Parameterised by DATA_WIDTH and MEM_BYTES.

Test Plan:
- AW 0x10 and W 0xDEADBEEF/WSTRB 1111 in the same cycle, BREADY=1 -> BVALID 2 cycles later, BRESP=00. Then AR 0x10 -> RVALID next cycle, RDATA=0xDEADBEEF, RRESP=00.
- W arrives 3 cycles before AW 0x20, WSTRB 0101, data 0x11223344, over prior word 0xAAAAAAAA -> readback 0xAA22AA44. WREADY stays low while W is held.
- AW 0x1000 (out of range), W 0xFFFFFFFF -> BRESP=10 and word 0 unchanged. AR 0x2000 -> RRESP=10, RDATA=0.
- BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout, and a new AWVALID is not accepted. RREADY low 4 cycles -> RDATA stable, ARREADY=0.
- Write commit to 0x30 (old 0x1, new 0x2) and AR 0x30 sampled at the same edge -> RDATA=0x1. The next AR 0x30 -> RDATA=0x2.
- ARESET asserted while W is held and AW not yet seen -> after reset AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, and the target word is unchanged.
